// File: rtl/ram_burst_master.sv
// Burst master in front of a single-port sync RAM; optional RAM_BURST_MASTER_STATS_EN adds stat_beats.
// Latency: writes land the cycle wd is accepted; first read beat is 3 cycles after command accept.
// Backpressure: wd_valid stalls pause writes; rd_ready low holds the 2-entry read buffer and throttles issue.
module ram_burst_master #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [7:0]    cmd_len,
  input  logic          wd_valid,
  output logic          wd_ready,
  input  logic [DW-1:0] wd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_D,
  input  logic [DW-1:0] MEM_Q,
  output logic          busy,
  output logic          done
`ifdef RAM_BURST_MASTER_STATS_EN
  ,
  output logic [15:0]   stat_beats
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] mem_addr_q;
  logic [7:0]    iss_left_q, iss_left_d;
  logic [7:0]    rd_left_q, rd_left_d;
  logic          done_q, done_d;

  logic [DW-1:0] buf_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    occ_q;
  logic          inflight_q;
  logic          can_issue, issue, push, pop;

  // Issue only while buffer entries plus the outstanding read fit in two slots.
  assign can_issue = (occ_q == 2'd0) || ((occ_q == 2'd1) && !inflight_q);
  assign push      = inflight_q;
  assign rd_valid  = (occ_q != 2'd0);
  assign rd_data   = buf_q[rd_ptr_q];
  assign pop       = rd_valid && rd_ready;
  assign MEM_D     = wd_data;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    iss_left_d = iss_left_q;
    rd_left_d  = rd_left_q;
    done_d     = 1'b0;
    cmd_ready  = 1'b0;
    wd_ready   = 1'b0;
    MEM_WE     = 1'b0;
    MEM_ADDR   = mem_addr_q;
    issue      = 1'b0;
    if (pop) rd_left_d = rd_left_q - 8'd1;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d    = cmd_write ? WRITE : READ;
          addr_d     = cmd_addr;
          iss_left_d = cmd_len;
          rd_left_d  = cmd_len;
        end
      end
      WRITE: begin
        wd_ready = 1'b1;
        MEM_WE   = wd_valid;
        MEM_ADDR = addr_q;
        if (wd_valid) begin
          addr_d     = addr_q + AW'(1);
          iss_left_d = iss_left_q - 8'd1;
          if (iss_left_q == 8'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      READ: begin
        if (can_issue) begin
          issue      = 1'b1;
          MEM_ADDR   = addr_q;
          addr_d     = addr_q + AW'(1);
          iss_left_d = iss_left_q - 8'd1;
          if (iss_left_q == 8'd0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (rd_left_q == 8'd0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      iss_left_q <= '0;
      rd_left_q  <= '0;
      done_q     <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_addr_q <= MEM_ADDR;
      iss_left_q <= iss_left_d;
      rd_left_q  <= rd_left_d;
      done_q     <= done_d;
      inflight_q <= issue;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // RAM returns data one cycle after issue; capture it straight into the buffer.
  always_ff @(posedge CLK) begin
    if (push) buf_q[wr_ptr_q] <= MEM_Q;
  end

`ifdef RAM_BURST_MASTER_STATS_EN
  logic [15:0] stat_q;
  always_ff @(posedge CLK) begin
    if (!RST_X)
      stat_q <= 16'd0;
    else if ((MEM_WE || pop) && (stat_q != 16'hFFFF))
      stat_q <= stat_q + 16'd1;
  end
  assign stat_beats = stat_q;
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural single-port RAM.
// Latency: checks first read beat 3 cycles after accept, writes same cycle as wd handshake.
// Backpressure: exercises wd_valid stalls and rd_ready throttling one cycle in three.
module tb_ram_burst_master;

    logic       CLK = 1'b0;
    logic       RST_X;
    logic       cmd_valid, cmd_write;
    logic [7:0] cmd_addr, cmd_len;
    logic       cmd_ready;
    logic       wd_valid, wd_ready;
    logic [7:0] wd_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic [7:0] MEM_ADDR, MEM_D, MEM_Q;
    logic       MEM_WE;
    logic       busy, done;
`ifdef RAM_BURST_MASTER_STATS_EN
    logic [15:0] stat_beats;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [256];

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_ADDR] <= MEM_D;
        MEM_Q <= mem[MEM_ADDR];
    end

    ram_burst_master #(.AW(8), .DW(8)) dut (
        .CLK(CLK), .RST_X(RST_X),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_D(MEM_D), .MEM_Q(MEM_Q),
        .busy(busy), .done(done)
`ifdef RAM_BURST_MASTER_STATS_EN
        , .stat_beats(stat_beats)
`endif
    );

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [7:0] len);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
        #1;
        chk("cmd_ready_idle", cmd_ready === 1'b1, cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wr_burst(input logic [7:0] a, input logic [7:0] len, input logic [7:0] d0, input int stall_at);
        logic [7:0] ea, ed;
        send_cmd(1'b1, a, len);
        for (int i = 0; i <= int'(len); i++) begin
            if (i == stall_at) begin
                wd_valid = 1'b0;
                #1;
                chk("wr_stall_we", MEM_WE === 1'b0, MEM_WE, 1'b0);
                chk("wr_stall_wd_ready", wd_ready === 1'b1, wd_ready, 1'b1);
                step();
            end
            ea = a + 8'(i);
            ed = d0 + 8'(i);
            wd_valid = 1'b1; wd_data = ed;
            #1;
            chk("wr_we", MEM_WE === 1'b1, MEM_WE, 1'b1);
            chk("wr_addr", MEM_ADDR === ea, MEM_ADDR, ea);
            chk("wr_d", MEM_D === ed, MEM_D, ed);
            chk("wr_done_early", done === 1'b0, done, 1'b0);
            step();
        end
        wd_valid = 1'b0;
        #1;
        chk("wr_done_pulse", done === 1'b1, done, 1'b1);
        chk("wr_busy_fall", busy === 1'b0, busy, 1'b0);
        chk("wr_wd_ready_idle", wd_ready === 1'b0, wd_ready, 1'b0);
        step();
        chk("wr_done_once", done === 1'b0, done, 1'b0);
    endtask

    task automatic rd_burst(input logic [7:0] a, input logic [7:0] len, input logic [7:0] d0, input logic throttle);
        int n = 0;
        int cyc = 1;
        bit seen = 0;
        bit held = 0;
        logic [7:0] held_d, ed;
        send_cmd(1'b0, a, len);
        while (n <= int'(len) && cyc < 200) begin
            rd_ready = throttle ? ((cyc % 3) == 0) : 1'b1;
            #1;
            chk("rd_we_low", MEM_WE === 1'b0, MEM_WE, 1'b0);
            if (cyc == 1) chk("rd_first_addr", MEM_ADDR === a, MEM_ADDR, a);
            if (held) begin
                chk("rd_hold_valid", rd_valid === 1'b1, rd_valid, 1'b1);
                chk("rd_hold_data", rd_data === held_d, rd_data, held_d);
            end
            held = 0;
            if (rd_valid) begin
                if (!seen) chk("rd_first_latency", cyc == 3, cyc, 3);
                seen = 1;
                ed = d0 + 8'(n);
                chk("rd_data", rd_data === ed, rd_data, ed);
                if (rd_ready) n++;
                else begin
                    held = 1;
                    held_d = rd_data;
                end
            end
            step();
            cyc++;
        end
        chk("rd_beat_count", n == int'(len) + 1, n, int'(len) + 1);
        rd_ready = 1'b0;
        #1;
        chk("rd_done_pulse", done === 1'b1, done, 1'b1);
        chk("rd_busy_fall", busy === 1'b0, busy, 1'b0);
        chk("rd_valid_empty", rd_valid === 1'b0, rd_valid, 1'b0);
        step();
        chk("rd_done_once", done === 1'b0, done, 1'b0);
    endtask

    initial begin
        int n;
        RST_X = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = 8'h00;
        wd_valid = 1'b0; wd_data = 8'h00; rd_ready = 1'b0;
        step();
        step();
        chk("rst_cmd_ready", cmd_ready === 1'b1, cmd_ready, 1'b1);
        chk("rst_wd_ready", wd_ready === 1'b0, wd_ready, 1'b0);
        chk("rst_rd_valid", rd_valid === 1'b0, rd_valid, 1'b0);
        chk("rst_mem_we", MEM_WE === 1'b0, MEM_WE, 1'b0);
        chk("rst_mem_addr", MEM_ADDR === 8'h00, MEM_ADDR, 8'h00);
        chk("rst_busy", busy === 1'b0, busy, 1'b0);
        chk("rst_done", done === 1'b0, done, 1'b0);
`ifdef RAM_BURST_MASTER_STATS_EN
        chk("rst_stat", stat_beats === 16'd0, stat_beats, 16'd0);
`endif
        RST_X = 1'b1;
        step();

        wr_burst(8'h10, 8'd3, 8'hA0, -1);
        rd_burst(8'h10, 8'd3, 8'hA0, 1'b0);
`ifdef RAM_BURST_MASTER_STATS_EN
        chk("stat_after_wr_rd", stat_beats === 16'd8, stat_beats, 16'd8);
`endif

        wr_burst(8'h14, 8'd3, 8'hA4, -1);
        wr_burst(8'hFE, 8'd2, 8'hC0, 1);
        rd_burst(8'hFE, 8'd2, 8'hC0, 1'b0);
        chk("wrap_mem_00", mem[8'h00] === 8'hC2, mem[8'h00], 8'hC2);
        chk("wrap_mem_ff", mem[8'hFF] === 8'hC1, mem[8'hFF], 8'hC1);

        rd_burst(8'h10, 8'd7, 8'hA0, 1'b1);

        send_cmd(1'b0, 8'h10, 8'd7);
        rd_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 2; c++) begin
            #1;
            if (rd_valid) n++;
            step();
        end
        chk("mid_beats_taken", n == 2, n, 2);
        chk("mid_busy", busy === 1'b1, busy, 1'b1);
        RST_X = 1'b0;
        step();
        chk("mid_rst_rd_valid", rd_valid === 1'b0, rd_valid, 1'b0);
        chk("mid_rst_mem_we", MEM_WE === 1'b0, MEM_WE, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready === 1'b1, cmd_ready, 1'b1);
        chk("mid_rst_busy", busy === 1'b0, busy, 1'b0);
        chk("mid_rst_mem_addr", MEM_ADDR === 8'h00, MEM_ADDR, 8'h00);
        RST_X = 1'b1;
        rd_ready = 1'b0;
        step();
        chk("post_rst_rd_valid", rd_valid === 1'b0, rd_valid, 1'b0);
        rd_burst(8'h10, 8'd3, 8'hA0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 SHALL have parameter AW, default 8: memory address width; addresses wrap modulo 2^AW.
REQ-002 SHALL have parameter DW, default 8: memory data width.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST_X  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_write  input  1  1=write burst, 0=read burst.
REQ-008 SHALL have port cmd_addr  input  AW  burst start address.
REQ-009 SHALL have port cmd_len  input  8  beats minus one (1..256 beats).
REQ-010 SHALL have port wd_valid  input  1  write data offered.
REQ-011 SHALL have port wd_ready  output  1  write data accepted.
REQ-012 SHALL have port wd_data  input  DW  write beat data.
REQ-013 SHALL have port rd_valid  output  1  read beat available.
REQ-014 SHALL have port rd_ready  input  1  sink accepts read beat.
REQ-015 SHALL have port rd_data  output  DW  read beat data.
REQ-016 SHALL have ports MEM_ADDR output AW, MEM_WE output 1, MEM_D output DW, MEM_Q input DW: single-port RAM, synchronous write, read data valid the cycle after MEM_ADDR is presented.
REQ-017 SHALL have ports busy output 1 (not IDLE) and done output 1 (one-cycle pulse).

Function
REQ-018 SHALL implement states IDLE, WRITE, READ, DRAIN.
REQ-019 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready latch addr/len/dir and enter WRITE or READ next cycle.
REQ-020 SHALL in WRITE drive wd_ready=1, MEM_WE=wd_valid, MEM_ADDR=current address, MEM_D=wd_data combinationally; each wd handshake is one beat; address increments by 1 with wrap (2^AW-1 -> 0).
REQ-021 SHALL in WRITE, after beat cmd_len+1, return to IDLE and pulse done in the following cycle; wd_valid stalls pause the burst with MEM_WE=0.
REQ-022 SHALL keep MEM_WE=0 and wd_ready=0 in every state other than WRITE.
REQ-023 SHALL contain a 2-entry read buffer; in READ issue one read (MEM_ADDR=address, increment) per cycle only while buffer occupancy plus in-flight reads < 2.
REQ-024 SHALL capture MEM_Q into the buffer in the cycle after issue; rd_valid/rd_data present the buffer head; first rd_valid no earlier than 3 cycles after command acceptance.
REQ-025 SHALL allow a simultaneous buffer push and pop without loss or reordering; rd_ready low SHALL never drop data.
REQ-026 SHALL enter DRAIN after the last read is issued, return to IDLE when the last beat is accepted, and pulse done the following cycle.
REQ-027 SHALL hold rd_data stable while rd_valid=1 and rd_ready=0.
REQ-028 SHALL hold MEM_ADDR at the last driven value when no access is issued.

Reset
REQ-029 SHALL, with RST_X=0 at a rising edge, enter IDLE, flush the buffer, discard in-flight reads, and clear address/beat counters, regardless of burst progress.
REQ-030 SHALL during and after reset present cmd_ready=1 (IDLE), wd_ready=0, rd_valid=0, MEM_WE=0, MEM_ADDR=0, busy=0, done=0.

Configuration
REQ-031 SHALL, with RAM_BURST_MASTER_STATS_EN defined, add output stat_beats[15:0]: count of completed beats (write MEM_WE cycles plus read rd handshakes), saturating at 0xFFFF, cleared by reset.
REQ-032 SHALL, without RAM_BURST_MASTER_STATS_EN, omit stat_beats and its logic; all other behaviour identical.

Verification
REQ-033 Write addr=0x10 len=3, data A0..A3 continuous -> MEM_WE on 4 cycles at 0x10..0x13, done pulse once, busy falls.
REQ-034 Read addr=0x10 len=3, rd_ready=1 -> rd_data A0,A1,A2,A3 in order, first rd_valid 3 cycles after accept.
REQ-035 Write addr=0xFE len=2 then read same -> accesses 0xFE,0xFF,0x00; data matches.
REQ-036 Read len=7 with rd_ready toggling 1-of-3 cycles -> 8 beats, no loss/duplication, occupancy never >2.
REQ-037 RST_X=0 mid read burst at beat 2 -> next cycle rd_valid=0, MEM_WE=0, cmd_ready=1; new command runs cleanly.
REQ-038 With RAM_BURST_MASTER_STATS_EN, after REQ-033 and REQ-034 -> stat_beats=8.
